vx_flush_ctrl: RTL and testbench



---
 rtl/vx_flush_ctrl_pkg.sv | 44 ++++
 rtl/vx_flush_ctrl.sv | 164 ++++++++++++++++
 tb/tb_vx_flush_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vx_flush_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vx_flush_ctrl_pkg
//   Shared cache package for the per-bank flush sequencer.
//   - flush_state_t : states of the flush sequencer FSM
//   - calc_*        : geometry helpers that derive the bank's line count,
//                     line-select width and line-address width from the
//                     cache parameters.
// ---------------------------------------------------------------------------
package vx_flush_ctrl_pkg;

    typedef enum logic [2:0] {
        FS_INIT  = 3'd0,   // post-reset walk
        FS_IDLE  = 3'd1,   // waiting for a flush request
        FS_DRAIN = 3'd2,   // waiting for outstanding fills to retire
        FS_FLUSH = 3'd3,   // requested walk
        FS_ACK   = 3'd4    // completion pending at the consumer
    } flush_state_t;

    // Number of lines held by one bank.
    function automatic int calc_lines_per_bank(input int cache_size,
                                               input int line_size,
                                               input int num_banks);
        int lpb;
        lpb = cache_size / (line_size * num_banks);
        return (lpb < 1) ? 1 : lpb;
    endfunction

    // Width of the line-select counter, never below one bit so that a
    // single-line bank still has a real register.
    function automatic int calc_line_select_bits(input int lines_per_bank);
        return (lines_per_bank > 1) ? $clog2(lines_per_bank) : 1;
    endfunction

    // Line address width: 32-bit byte address reduced to word address,
    // then to line address.
    function automatic int calc_line_addr_width(input int line_size,
                                                input int word_size);
        int words_per_line;
        words_per_line = line_size / word_size;
        if (words_per_line < 1) words_per_line = 1;
        return 32 - $clog2(word_size) - $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/vx_flush_ctrl.sv
// ---------------------------------------------------------------------------
// vx_flush_ctrl
//   Per-bank flush sequencer placed directly upstream of the bank's tag
//   store. It walks every line index of the bank and drives the tag store's
//   flush input, invalidating each line. A walk runs automatically after
//   reset and again for each accepted external flush request. While any
//   walk (or its drain / completion phase) is in progress, busy holds off
//   the bank's core-request intake.
//
// Optional feature macro: CACHE_FLUSH_PERF_EN
//   When defined, adds perf_flush_count and perf_drain_cycles outputs.
//
// Ports
//   clk               in   clock
//   reset             in   synchronous, active-high reset
//   flush_req_valid   in   external flush request
//   flush_req_ready   out  request accepted when high together with valid
//   flush_rsp_valid   out  flush complete
//   flush_rsp_ready   in   consumer takes the completion
//   mshr_empty        in   no outstanding fills in the bank
//   stall             in   bank pipeline stall (also gates the tag store)
//   flush_valid       out  to tag store flush input
//   flush_addr        out  line address being flushed
//   busy              out  blocks core request intake
//   perf_flush_count  out  (CACHE_FLUSH_PERF_EN) completed requested flushes
//   perf_drain_cycles out  (CACHE_FLUSH_PERF_EN) cycles spent in DRAIN
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high; valid, once raised, is held until that edge and its
// payload does not change meanwhile; ready never depends combinationally
// on valid.
// ---------------------------------------------------------------------------
module vx_flush_ctrl
    import vx_flush_ctrl_pkg::*;
#(
    parameter int CACHE_ID        = 0,
    parameter int BANK_ID         = 0,
    parameter int CACHE_SIZE      = 1,
    parameter int CACHE_LINE_SIZE = 1,
    parameter int NUM_BANKS       = 1,
    parameter int WORD_SIZE       = 1,
    // Derived geometry; not meant to be overridden.
    parameter int LINES_PER_BANK   = calc_lines_per_bank(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS),
    parameter int LINE_SELECT_BITS = calc_line_select_bits(LINES_PER_BANK),
    parameter int LINE_ADDR_WIDTH  = calc_line_addr_width(CACHE_LINE_SIZE, WORD_SIZE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_req_valid,
    output logic                       flush_req_ready,
    output logic                       flush_rsp_valid,
    input  logic                       flush_rsp_ready,
    input  logic                       mshr_empty,
    input  logic                       stall,
    output logic                       flush_valid,
    output logic [LINE_ADDR_WIDTH-1:0] flush_addr,
`ifdef CACHE_FLUSH_PERF_EN
    output logic [31:0]                perf_flush_count,
    output logic [31:0]                perf_drain_cycles,
`endif
    output logic                       busy
);

    localparam logic [LINE_SELECT_BITS-1:0] LAST_LINE =
        LINE_SELECT_BITS'(LINES_PER_BANK - 1);

    flush_state_t                r_state;
    flush_state_t                w_state_n;
    logic [LINE_SELECT_BITS-1:0] r_counter;
    logic [LINE_SELECT_BITS-1:0] w_counter_n;
    logic                        w_walking;
    logic                        w_last_line;

    assign w_walking   = (r_state == FS_INIT) || (r_state == FS_FLUSH);
    assign w_last_line = (r_counter == LAST_LINE);

    // ------------------------------------------------------------------
    // State and line counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FS_INIT;
            r_counter <= '0;
        end else begin
            r_state   <= w_state_n;
            r_counter <= w_counter_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A stalled walk cycle leaves both the state and
    // the counter untouched, so the same line is presented again and no
    // line is skipped or repeated once the stall clears.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n   = r_state;
        w_counter_n = r_counter;
        case (r_state)
            FS_INIT, FS_FLUSH: begin
                if (!stall) begin
                    if (w_last_line) begin
                        w_counter_n = '0;
                        w_state_n   = (r_state == FS_INIT) ? FS_IDLE : FS_ACK;
                    end else begin
                        w_counter_n = r_counter + 1'b1;
                    end
                end
            end
            FS_IDLE: begin
                if (flush_req_valid) begin
                    w_state_n = FS_DRAIN;
                end
            end
            FS_DRAIN: begin
                // Fills still in flight would re-validate lines behind the
                // walk, so the walk only starts once the MSHR is empty.
                if (mshr_empty) begin
                    w_state_n = FS_FLUSH;
                end
            end
            FS_ACK: begin
                if (flush_rsp_ready) begin
                    w_state_n = FS_IDLE;
                end
            end
            default: begin
                w_state_n   = FS_INIT;
                w_counter_n = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore: everything is a function of the state)
    // ------------------------------------------------------------------
    assign flush_valid     = w_walking;
    assign flush_addr      = LINE_ADDR_WIDTH'(r_counter);
    assign busy            = (r_state != FS_IDLE);
    assign flush_req_ready = (r_state == FS_IDLE);
    assign flush_rsp_valid = (r_state == FS_ACK);

`ifdef CACHE_FLUSH_PERF_EN
    logic [31:0] r_perf_flush_count;
    logic [31:0] r_perf_drain_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_flush_count  <= '0;
            r_perf_drain_cycles <= '0;
        end else begin
            if ((r_state == FS_ACK) && flush_rsp_ready) begin
                r_perf_flush_count <= r_perf_flush_count + 32'd1;
            end
            if (r_state == FS_DRAIN) begin
                r_perf_drain_cycles <= r_perf_drain_cycles + 32'd1;
            end
        end
    end

    assign perf_flush_count  = r_perf_flush_count;
    assign perf_drain_cycles = r_perf_drain_cycles;
`endif

endmodule

// File: tb/tb_vx_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vx_flush_ctrl
//   Directed bench for vx_flush_ctrl with CACHE_SIZE=256, CACHE_LINE_SIZE=16,
//   NUM_BANKS=4, WORD_SIZE=4 (four lines per bank, 28-bit line address).
//   Each vector is one clock cycle: inputs are driven just after a rising
//   edge and the outputs of that cycle are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_vx_flush_ctrl;

    localparam int AW = 28;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush_req_valid;
    logic          flush_req_ready;
    logic          flush_rsp_valid;
    logic          flush_rsp_ready;
    logic          mshr_empty;
    logic          stall;
    logic          flush_valid;
    logic [AW-1:0] flush_addr;
    logic          busy;
`ifdef CACHE_FLUSH_PERF_EN
    logic [31:0]   perf_flush_count;
    logic [31:0]   perf_drain_cycles;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic    st;
        logic    me;
        logic    rv;
        logic    rr;
        logic    fv;
        int      addr;
        logic    bsy;
        logic    rq;
        logic    rs;
    } vec_t;

    vec_t vecs[$];

    vx_flush_ctrl #(
        .CACHE_ID        (0),
        .BANK_ID         (0),
        .CACHE_SIZE      (256),
        .CACHE_LINE_SIZE (16),
        .NUM_BANKS       (4),
        .WORD_SIZE       (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush_req_valid (flush_req_valid),
        .flush_req_ready (flush_req_ready),
        .flush_rsp_valid (flush_rsp_valid),
        .flush_rsp_ready (flush_rsp_ready),
        .mshr_empty      (mshr_empty),
        .stall           (stall),
        .flush_valid     (flush_valid),
        .flush_addr      (flush_addr),
`ifdef CACHE_FLUSH_PERF_EN
        .perf_flush_count  (perf_flush_count),
        .perf_drain_cycles (perf_drain_cycles),
`endif
        .busy            (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic me, input logic rv, input logic rr,
                       input logic fv, input int addr, input logic bsy,
                       input logic rq, input logic rs);
        vec_t v;
        v.st = st; v.me = me; v.rv = rv; v.rr = rr;
        v.fv = fv; v.addr = addr; v.bsy = bsy; v.rq = rq; v.rs = rs;
        vecs.push_back(v);
    endtask

    // One cycle: drive, compare on the falling edge, advance past the
    // next rising edge.
    task automatic step(input string tag, input vec_t v);
        stall           = v.st;
        mshr_empty      = v.me;
        flush_req_valid = v.rv;
        flush_rsp_ready = v.rr;
        @(negedge clk);
        check({tag, ".flush_valid"}, int'(flush_valid),     int'(v.fv));
        check({tag, ".flush_addr"},  int'(flush_addr),      v.addr);
        check({tag, ".busy"},        int'(busy),            int'(v.bsy));
        check({tag, ".req_ready"},   int'(flush_req_ready), int'(v.rq));
        check({tag, ".rsp_valid"},   int'(flush_rsp_valid), int'(v.rs));
        @(posedge clk);
        #1;
    endtask

    task automatic step_v(input string tag,
                          input logic st, input logic me, input logic rv, input logic rr,
                          input logic fv, input int addr, input logic bsy,
                          input logic rq, input logic rs);
        vec_t v;
        v.st = st; v.me = me; v.rv = rv; v.rr = rr;
        v.fv = fv; v.addr = addr; v.bsy = bsy; v.rq = rq; v.rs = rs;
        step(tag, v);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Vector table, one entry per cycle after reset release.
        //     st me rv rr   fv addr busy rq rs
        // post-reset walk
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1,   1, i, 1, 0, 0);
        // IDLE, request accepted here
        add(0, 1, 1, 1,   0, 0, 0, 1, 0);
        // DRAIN
        add(0, 1, 0, 1,   0, 0, 1, 0, 0);
        // requested walk
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1,   1, i, 1, 0, 0);
        // ACK, consumer ready: 6 cycles after accept
        add(0, 1, 0, 1,   0, 0, 1, 0, 1);
        // IDLE again, second request accepted with fills outstanding
        add(0, 0, 1, 1,   0, 0, 0, 1, 0);
        // DRAIN with mshr_empty low for 5 cycles (stall here is ignored)
        add(0, 0, 0, 1,   0, 0, 1, 0, 0);
        add(1, 0, 0, 1,   0, 0, 1, 0, 0);
        add(0, 0, 1, 1,   0, 0, 1, 0, 0);
        add(0, 0, 0, 1,   0, 0, 1, 0, 0);
        add(0, 0, 0, 1,   0, 0, 1, 0, 0);
        // mshr_empty rises while stalled: still leaves DRAIN
        add(1, 1, 0, 1,   0, 0, 1, 0, 0);
        // walk with a 3-cycle stall on line 2
        add(0, 1, 0, 1,   1, 0, 1, 0, 0);
        add(0, 1, 0, 1,   1, 1, 1, 0, 0);
        add(1, 1, 0, 1,   1, 2, 1, 0, 0);
        add(1, 1, 0, 1,   1, 2, 1, 0, 0);
        add(1, 1, 0, 1,   1, 2, 1, 0, 0);
        add(0, 1, 0, 1,   1, 2, 1, 0, 0);
        add(0, 1, 0, 1,   1, 3, 1, 0, 0);
        // ACK held for 10 cycles with a competing request (and some stall)
        for (int i = 0; i < 10; i++) add(logic'(i % 3 == 0), 1, 1, 0,   0, 0, 1, 0, 1);
        add(0, 1, 1, 1,   0, 0, 1, 0, 1);
        // back in IDLE
        add(0, 1, 0, 1,   0, 0, 0, 1, 0);

        // ---- reset ----
        reset           = 1'b1;
        stall           = 1'b0;
        mshr_empty      = 1'b1;
        flush_req_valid = 1'b0;
        flush_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst.flush_valid", int'(flush_valid),     1);
        check("rst.flush_addr",  int'(flush_addr),      0);
        check("rst.busy",        int'(busy),            1);
        check("rst.req_ready",   int'(flush_req_ready), 0);
        check("rst.rsp_valid",   int'(flush_rsp_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // ---- reset during the requested walk at line 2 ----
        step_v("r6.accept", 0, 1, 1, 1,   0, 0, 0, 1, 0);
        step_v("r6.drain",  0, 1, 0, 1,   0, 0, 1, 0, 0);
        step_v("r6.l0",     0, 1, 0, 1,   1, 0, 1, 0, 0);
        step_v("r6.l1",     0, 1, 0, 1,   1, 1, 1, 0, 0);
        reset = 1'b1;
        step_v("r6.l2rst",  0, 1, 0, 1,   1, 2, 1, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step_v($sformatf("r6.init%0d", i), 0, 1, 0, 1,   1, i, 1, 0, 0);
        step_v("r6.idle",   0, 1, 0, 1,   0, 0, 0, 1, 0);

        // ---- reset while a completion is pending drops it ----
        step_v("ra.accept", 0, 1, 1, 0,   0, 0, 0, 1, 0);
        step_v("ra.drain",  0, 1, 0, 0,   0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step_v($sformatf("ra.l%0d", i), 0, 1, 0, 0,   1, i, 1, 0, 0);
        step_v("ra.ack",    0, 1, 0, 0,   0, 0, 1, 0, 1);
        reset = 1'b1;
        step_v("ra.ackrst", 0, 1, 0, 0,   0, 0, 1, 0, 1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step_v($sformatf("ra.init%0d", i), 0, 1, 0, 0,   1, i, 1, 0, 0);
        step_v("ra.idle",   0, 1, 0, 0,   0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
